// File: rtl/e203_exu_brchslv_flush.sv
// rtl/e203_exu_brchslv_flush.sv - branch-resolve commit check and registered IFU flush request
// Optional flush-event counter: E203_BRCHSLV_PERF_CNT_EN

`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif
`ifndef E203_XLEN
`define E203_XLEN 32
`endif

module e203_exu_brchslv_flush (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmt_i_valid,
  output logic                     cmt_i_ready,
  input  logic                     cmt_i_bjp,
  input  logic                     cmt_i_mret,
  input  logic                     cmt_i_dret,
  input  logic                     cmt_i_fencei,
  input  logic                     cmt_i_prdt,
  input  logic                     cmt_i_rslv,
  input  logic                     cmt_i_rv32,
  input  logic [`E203_PC_SIZE-1:0] cmt_i_pc,
  input  logic [`E203_XLEN-1:0]    cmt_i_imm,
  input  logic [`E203_PC_SIZE-1:0] csr_epc_r,
  input  logic [`E203_PC_SIZE-1:0] csr_dpc_r,
  output logic                     brchmis_flush_req,
  input  logic                     brchmis_flush_ack,
  output logic [`E203_PC_SIZE-1:0] brchmis_flush_pc,
  output logic [31:0]              brchmis_cnt
);

  localparam int PC_SIZE = `E203_PC_SIZE;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 cmt_ena;
  logic                 need_flush;
  logic                 mis_nt;
  logic                 mis_t;
  logic                 load;
  logic [PC_SIZE-1:0]   seq_pc;
  logic [PC_SIZE-1:0]   tgt_pc;
  logic [PC_SIZE-1:0]   flush_pc_d;
  logic [PC_SIZE-1:0]   flush_pc_q;

  assign cmt_i_ready = (state_q == IDLE);
  assign cmt_ena     = cmt_i_valid & cmt_i_ready;

  assign mis_nt     = cmt_i_bjp & cmt_i_prdt & ~cmt_i_rslv;
  assign mis_t      = cmt_i_bjp & ~cmt_i_prdt & cmt_i_rslv;
  assign need_flush = mis_nt | mis_t | cmt_i_mret | cmt_i_dret | cmt_i_fencei;

  assign seq_pc = cmt_i_pc + {{(PC_SIZE-3){1'b0}}, cmt_i_rv32, ~cmt_i_rv32, 1'b0};
  assign tgt_pc = cmt_i_pc + cmt_i_imm[PC_SIZE-1:0];

  // Only a resolved-taken mispredict can reach the final branch of the chain.
  always_comb begin
    flush_pc_d = tgt_pc;
    if (cmt_i_mret)
      flush_pc_d = csr_epc_r;
    else if (cmt_i_dret)
      flush_pc_d = csr_dpc_r;
    else if (cmt_i_fencei | mis_nt)
      flush_pc_d = seq_pc;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmt_ena & need_flush) begin
          load    = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (brchmis_flush_ack)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      flush_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (load)
        flush_pc_q <= flush_pc_d;
    end
  end

  assign brchmis_flush_req = (state_q == PEND);
  assign brchmis_flush_pc  = flush_pc_q;

`ifdef E203_BRCHSLV_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (load)
      cnt_q <= cnt_q + 32'd1;
  end

  assign brchmis_cnt = cnt_q;
`else
  assign brchmis_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_e203_exu_brchslv_flush.sv
// tb/tb_e203_exu_brchslv_flush.sv - scoreboard bench for e203_exu_brchslv_flush

module tb_e203_exu_brchslv_flush;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmt_i_valid, cmt_i_ready;
  logic        cmt_i_bjp, cmt_i_mret, cmt_i_dret, cmt_i_fencei;
  logic        cmt_i_prdt, cmt_i_rslv, cmt_i_rv32;
  logic [31:0] cmt_i_pc, cmt_i_imm, csr_epc_r, csr_dpc_r;
  logic        brchmis_flush_req, brchmis_flush_ack;
  logic [31:0] brchmis_flush_pc, brchmis_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_cnt = 32'd0;
  logic        req_prev = 1'b0;

  always #5 clk = ~clk;

  e203_exu_brchslv_flush dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmt_i_valid       (cmt_i_valid),
    .cmt_i_ready       (cmt_i_ready),
    .cmt_i_bjp         (cmt_i_bjp),
    .cmt_i_mret        (cmt_i_mret),
    .cmt_i_dret        (cmt_i_dret),
    .cmt_i_fencei      (cmt_i_fencei),
    .cmt_i_prdt        (cmt_i_prdt),
    .cmt_i_rslv        (cmt_i_rslv),
    .cmt_i_rv32        (cmt_i_rv32),
    .cmt_i_pc          (cmt_i_pc),
    .cmt_i_imm         (cmt_i_imm),
    .csr_epc_r         (csr_epc_r),
    .csr_dpc_r         (csr_dpc_r),
    .brchmis_flush_req (brchmis_flush_req),
    .brchmis_flush_ack (brchmis_flush_ack),
    .brchmis_flush_pc  (brchmis_flush_pc),
    .brchmis_cnt       (brchmis_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pops one expected redirect PC on every rising edge of the flush request.
  always @(negedge clk) begin
    if (rst_n && brchmis_flush_req && !req_prev) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_flush: got pc %h expected no flush", brchmis_flush_pc);
      end else begin
        chk("flush_pc", brchmis_flush_pc, sb.pop_front());
      end
    end
    req_prev = brchmis_flush_req;
  end

  task automatic drive(input logic bjp, mret, dret, fencei, prdt, rslv, rv32,
                       input logic [31:0] pc, imm);
    cmt_i_bjp    = bjp;
    cmt_i_mret   = mret;
    cmt_i_dret   = dret;
    cmt_i_fencei = fencei;
    cmt_i_prdt   = prdt;
    cmt_i_rslv   = rslv;
    cmt_i_rv32   = rv32;
    cmt_i_pc     = pc;
    cmt_i_imm    = imm;
    cmt_i_valid  = 1'b1;
  endtask

  task automatic expect_flush(input logic [31:0] pc);
    sb.push_back(pc);
`ifdef E203_BRCHSLV_PERF_CNT_EN
    exp_cnt = exp_cnt + 32'd1;
`endif
  endtask

  // Called just after a falling edge while the block is idle.
  task automatic commit(input logic bjp, mret, dret, fencei, prdt, rslv, rv32,
                        input logic [31:0] pc, imm, input logic flush, input logic [31:0] exp_pc);
    drive(bjp, mret, dret, fencei, prdt, rslv, rv32, pc, imm);
    if (flush) expect_flush(exp_pc);
    @(negedge clk);
    cmt_i_valid = 1'b0;
    chk("req_after_commit", {31'd0, brchmis_flush_req}, {31'd0, flush});
    chk("ready_after_commit", {31'd0, cmt_i_ready}, {31'd0, !flush});
  endtask

  task automatic do_ack;
    brchmis_flush_ack = 1'b1;
    @(negedge clk);
    brchmis_flush_ack = 1'b0;
    chk("req_after_ack", {31'd0, brchmis_flush_req}, 32'd0);
    chk("ready_after_ack", {31'd0, cmt_i_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    cmt_i_valid = 1'b0;
    brchmis_flush_ack = 1'b0;
    csr_epc_r = 32'h8000_0040;
    csr_dpc_r = 32'h0000_0800;
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    cmt_i_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, brchmis_flush_req}, 32'd0);
    chk("rst_pc", brchmis_flush_pc, 32'd0);
    chk("rst_ready", {31'd0, cmt_i_ready}, 32'd1);
    chk("rst_cnt", brchmis_cnt, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ack while idle must be ignored
    brchmis_flush_ack = 1'b1;
    @(negedge clk);
    brchmis_flush_ack = 1'b0;
    chk("idle_ack_req", {31'd0, brchmis_flush_req}, 32'd0);

    commit(1, 0, 0, 0, 1, 1, 1, 32'h8000_0100, 32'h0, 0, 32'h0);
    chk("cnt_no_flush", brchmis_cnt, 32'd0);

    // Not-taken mispredict, 16-bit; ack held low 3 cycles
    commit(1, 0, 0, 0, 1, 0, 0, 32'h8000_0100, 32'h0, 1, 32'h8000_0102);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_req", {31'd0, brchmis_flush_req}, 32'd1);
      chk("hold_pc", brchmis_flush_pc, 32'h8000_0102);
      chk("hold_ready", {31'd0, cmt_i_ready}, 32'd0);
    end
    do_ack();

    // Taken mispredict, ack in the first PEND cycle gives a 1-cycle pulse
    commit(1, 0, 0, 0, 0, 1, 1, 32'h8000_0200, 32'hFFFF_FFF0, 1, 32'h8000_01F0);
    do_ack();

    commit(0, 1, 0, 1, 0, 0, 1, 32'h8000_0300, 32'h0, 1, 32'h8000_0040);
    do_ack();
    commit(0, 0, 1, 0, 0, 0, 1, 32'h8000_0400, 32'h0, 1, 32'h0000_0800);
    do_ack();
    chk("cnt_after_4", brchmis_cnt, exp_cnt);

    // Back-pressure: a valid commit held during PEND waits, then is accepted
    commit(0, 0, 0, 1, 0, 0, 1, 32'h0000_1000, 32'h0, 1, 32'h0000_1004);
    drive(1, 0, 0, 0, 1, 0, 1, 32'h0000_2000, 32'h0);
    expect_flush(32'h0000_2004);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", {31'd0, cmt_i_ready}, 32'd0);
      chk("bp_pc", brchmis_flush_pc, 32'h0000_1004);
    end
    do_ack();
    @(negedge clk);
    cmt_i_valid = 1'b0;
    chk("bp_second_req", {31'd0, brchmis_flush_req}, 32'd1);
    chk("bp_second_pc", brchmis_flush_pc, 32'h0000_2004);
    chk("cnt_after_bp", brchmis_cnt, exp_cnt);

    // Asynchronous reset mid-PEND
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, brchmis_flush_req}, 32'd0);
    chk("async_rst_cnt", brchmis_cnt, 32'd0);
    exp_cnt = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, cmt_i_ready}, 32'd1);
    chk("post_rst_req", {31'd0, brchmis_flush_req}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      commit(1, 0, 0, 0, 0, 1, 1, 32'h0000_3000 + 32'(i * 16), 32'h40, 1,
             32'h0000_3040 + 32'(i * 16));
      do_ack();
    end
`ifdef E203_BRCHSLV_PERF_CNT_EN
    chk("cnt_five", brchmis_cnt, 32'd5);
    force dut.cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    chk("cnt_forced", brchmis_cnt, exp_cnt);
    commit(1, 0, 0, 0, 1, 0, 1, 32'h0000_5000, 32'h0, 1, 32'h0000_5004);
    do_ack();
    chk("cnt_wrap", brchmis_cnt, 32'd0);
`else
    chk("cnt_tied_zero", brchmis_cnt, 32'd0);
`endif
    chk("cnt_final", brchmis_cnt, exp_cnt);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
